// File: rtl/data_memory_be.sv
// Byte-addressable data memory for the MEM stage: one load or store per
// cycle, byte/half/word sizes, registered reads with sign/zero extension,
// error flagging without side effects, optional post-reset clear sweep.
module data_memory_be #(
    parameter int unsigned ADDR_BITS      = 16,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ready,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);
    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_BITS-1:0]   clear_cnt;
    logic [31:0]            mem [DEPTH];

    logic                   accept;
    logic [ADDR_BITS-1:0]   idx;
    logic [31:0]            addr_high;
    logic                   req_err;
    logic [3:0]             byte_en;
    logic [31:0]            wdata_lane;

    logic                   valid_q;
    logic                   err_q;
    logic                   load_q;
    logic [1:0]             size_q;
    logic                   uns_q;
    logic [1:0]             off_q;
    logic [31:0]            rd_word;
    logic [7:0]             byte_val;
    logic [15:0]            half_val;
    logic [31:0]            load_ext;

    // State register and clear counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR_ON_RESET ? INIT : RUN;
            clear_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                clear_cnt <= clear_cnt + 1'b1;
            end
        end
    end

    // Next-state: leave the sweep after the last word is cleared
    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (clear_cnt == '1) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    assign ready  = (state == RUN) && !reset;
    assign accept = req_valid && ready;
    assign idx    = req_addr[ADDR_BITS+1:2];

    // Request decode: error detection, byte enables and lane-replicated store data
    always_comb begin
        addr_high  = req_addr >> (ADDR_BITS + 2);
        req_err    = (addr_high != '0) || (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);
        byte_en    = 4'b1111;
        wdata_lane = req_wdata;
        case (req_size)
            2'b00: begin
                byte_en    = 4'b0001 << req_addr[1:0];
                wdata_lane = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{req_wdata[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                wdata_lane = req_wdata;
            end
        endcase
    end

    // Array writes: clear sweep or per-byte-enabled store (array has no reset)
    always_ff @(posedge clk) begin
        if (state == INIT && !reset) begin
            mem[clear_cnt] <= '0;
        end else if (accept && req_write && !req_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx][b*8 +: 8] <= wdata_lane[b*8 +: 8];
                end
            end
        end
    end

    // Registered read of the full word for valid loads
    always_ff @(posedge clk) begin
        if (accept && !req_write && !req_err) begin
            rd_word <= mem[idx];
        end
    end

    // Response bookkeeping for the request accepted this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
        end else begin
            valid_q <= accept;
            err_q   <= accept && req_err;
            load_q  <= accept && !req_write && !req_err;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            off_q   <= req_addr[1:0];
        end
    end

    // Lane extraction and extension; outputs are gated by reset so an
    // in-flight response is dropped in the cycle reset is asserted
    always_comb begin
        byte_val = rd_word[{off_q, 3'b000} +: 8];
        half_val = rd_word[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_ext = {{24{!uns_q && byte_val[7]}}, byte_val};
            2'b01:   load_ext = {{16{!uns_q && half_val[15]}}, half_val};
            default: load_ext = rd_word;
        endcase
        resp_valid = valid_q && !reset;
        resp_error = err_q && !reset;
        resp_rdata = (valid_q && load_q && !reset) ? load_ext : '0;
    end

endmodule

// File: tb/tb_data_memory_be.sv
// Self-checking bench for data_memory_be with ADDR_BITS = 4: a clearing
// instance checked against a byte-array reference model, and a
// non-clearing instance used for the retention-across-reset case.
module tb_data_memory_be;
    localparam int unsigned AB        = 4;
    localparam int unsigned MEM_BYTES = 4 * (2 ** AB);

    logic        clk = 1'b0;
    logic        reset, reset1;
    logic        ready, ready1;
    logic        req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error, resp_valid1, resp_error1;
    logic [31:0] resp_rdata, resp_rdata1;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [7:0]  model_mem [MEM_BYTES];
    logic        obs1_v;
    logic [31:0] obs1_d;

    always #5 clk = ~clk;

    data_memory_be #(.ADDR_BITS(AB), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .ready(ready), .req_valid(req_valid),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    data_memory_be #(.ADDR_BITS(AB), .CLEAR_ON_RESET(1'b0)) dut_keep (
        .clk(clk), .reset(reset1), .ready(ready1), .req_valid(req_valid),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid1),
        .resp_rdata(resp_rdata1), .resp_error(resp_error1)
    );

    // Reference: byte array, little-endian, rules applied arithmetically
    function automatic void model_access(input logic w, input logic [1:0] sz, input logic u,
                                         input logic [31:0] a, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic er);
        int unsigned n;
        logic [31:0] v;
        er = (a >= MEM_BYTES) || (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
             (sz == 2'd2 && a % 4 != 0);
        rd = 32'h0;
        if (er) return;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (w) begin
            for (int unsigned i = 0; i < n; i++) model_mem[a + i] = wd[8*i +: 8];
            return;
        end
        v = 32'h0;
        for (int unsigned i = 0; i < n; i++) v = v | (32'(model_mem[a + i]) << (8 * i));
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        rd = v;
    endfunction

    function automatic void model_clear();
        for (int unsigned i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'h00;
    endfunction

    // One isolated request; returns ready at issue and the response one cycle later
    task automatic xfer(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic rdy, output logic v, output logic e, output logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        #1 rdy = ready;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        v = resp_valid; e = resp_error; d = resp_rdata;
        obs1_v = resp_valid1; obs1_d = resp_rdata1;
    endtask

    // Counts low-ready samples from now until ready rises (bounded)
    task automatic count_ready_low(output int unsigned n);
        n = 0;
        #1;
        while (ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int unsigned n;
        @(negedge clk); #1;
        checks++;
        if ({ready, resp_valid, resp_error, resp_rdata, ready1} !== 36'h0) begin
            errors++;
            $display("FAIL reset_values: ready=%b valid=%b err=%b data=%h ready1=%b, want all 0",
                     ready, resp_valid, resp_error, resp_rdata, ready1);
        end
        @(negedge clk);
        reset = 1'b0; reset1 = 1'b0;
        #1;
        checks++;
        if (ready1 !== 1'b1) begin
            errors++;
            $display("FAIL noclear_ready_cycle0: ready1=%b, want 1", ready1);
        end
        count_ready_low(n);
        model_clear();
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL init_length: ready low for %0d cycles, want 16", n);
        end
    endtask

    task automatic test_clear_sweep();
        logic rdy, v, e; logic [31:0] d, ed; logic ee;
        int unsigned n;
        for (int unsigned i = 0; i < 16; i++) begin
            xfer(1'b1, 2'd2, 1'b0, 32'(i * 4), 32'hA5A5_0000 | 32'(i) + 32'h1, rdy, v, e, d);
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
        count_ready_low(n);
        model_clear();
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL init_length_preloaded: ready low for %0d cycles, want 16", n);
        end
        for (int unsigned i = 0; i < 16; i++) begin
            xfer(1'b0, 2'd2, 1'b0, 32'(i * 4), 32'h0, rdy, v, e, d);
            model_access(1'b0, 2'd2, 1'b0, 32'(i * 4), 32'h0, ed, ee);
            checks++;
            if (rdy !== 1'b1 || v !== 1'b1 || e !== 1'b0 || d !== 32'h0) begin
                errors++;
                $display("FAIL cleared_word_%0d: ready=%b valid=%b err=%b data=%h, want 1 1 0 00000000",
                         i, rdy, v, e, d);
            end
        end
    endtask

    task automatic test_extend();
        logic rdy, v, e; logic [31:0] d, ed; logic ee;
        logic [1:0]  sz [4]  = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic        un [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad [4]  = '{32'h9, 32'h9, 32'hA, 32'h8};
        logic [31:0] ex [4]  = '{32'hFFFF_FFCD, 32'h0000_00CD, 32'hFFFF_89AB, 32'h0000_CDEF};
        xfer(1'b1, 2'd2, 1'b0, 32'h8, 32'h89AB_CDEF, rdy, v, e, d);
        model_access(1'b1, 2'd2, 1'b0, 32'h8, 32'h89AB_CDEF, ed, ee);
        checks++;
        if (rdy !== 1'b1 || v !== 1'b1 || e !== 1'b0 || d !== 32'h0) begin
            errors++;
            $display("FAIL store_resp: ready=%b valid=%b err=%b data=%h, want 1 1 0 00000000", rdy, v, e, d);
        end
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, sz[i], un[i], ad[i], 32'h0, rdy, v, e, d);
            checks++;
            if (v !== 1'b1 || e !== 1'b0 || d !== ex[i]) begin
                errors++;
                $display("FAIL extend_%0d: valid=%b err=%b data=%h, want 1 0 %h", i, v, e, d, ex[i]);
            end
        end
    endtask

    task automatic test_partial();
        logic rdy, v, e; logic [31:0] d, ed; logic ee;
        xfer(1'b1, 2'd0, 1'b0, 32'hB, 32'hFFFF_FF5A, rdy, v, e, d);
        model_access(1'b1, 2'd0, 1'b0, 32'hB, 32'hFFFF_FF5A, ed, ee);
        xfer(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rdy, v, e, d);
        checks++;
        if (v !== 1'b1 || e !== 1'b0 || d !== 32'h5AAB_CDEF) begin
            errors++;
            $display("FAIL byte_store: valid=%b err=%b data=%h, want 1 0 5aabcdef", v, e, d);
        end
        xfer(1'b1, 2'd1, 1'b0, 32'h8, 32'hEEEE_1234, rdy, v, e, d);
        model_access(1'b1, 2'd1, 1'b0, 32'h8, 32'hEEEE_1234, ed, ee);
        xfer(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rdy, v, e, d);
        checks++;
        if (v !== 1'b1 || e !== 1'b0 || d !== 32'h5AAB_1234) begin
            errors++;
            $display("FAIL half_store: valid=%b err=%b data=%h, want 1 0 5aab1234", v, e, d);
        end
    endtask

    task automatic test_errors();
        logic rdy, v, e; logic [31:0] d, ed; logic ee;
        logic        wr [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0]  sz [4] = '{2'd2, 2'd1, 2'd2, 2'd3};
        logic [31:0] ad [4] = '{32'h6, 32'h3, 32'h40, 32'h4};
        logic [31:0] wa [2] = '{32'h0, 32'h4};
        xfer(1'b1, 2'd2, 1'b0, 32'h4, 32'h600D_BEEF, rdy, v, e, d);
        model_access(1'b1, 2'd2, 1'b0, 32'h4, 32'h600D_BEEF, ed, ee);
        xfer(1'b1, 2'd2, 1'b0, 32'h0, 32'h0BAD_F00D, rdy, v, e, d);
        model_access(1'b1, 2'd2, 1'b0, 32'h0, 32'h0BAD_F00D, ed, ee);
        for (int i = 0; i < 4; i++) begin
            xfer(wr[i], sz[i], 1'b0, ad[i], 32'hDEAD_DEAD, rdy, v, e, d);
            model_access(wr[i], sz[i], 1'b0, ad[i], 32'hDEAD_DEAD, ed, ee);
            checks++;
            if (v !== 1'b1 || e !== 1'b1 || d !== 32'h0) begin
                errors++;
                $display("FAIL error_%0d: valid=%b err=%b data=%h, want 1 1 00000000", i, v, e, d);
            end
        end
        for (int i = 0; i < 2; i++) begin
            xfer(1'b0, 2'd2, 1'b0, wa[i], 32'h0, rdy, v, e, d);
            model_access(1'b0, 2'd2, 1'b0, wa[i], 32'h0, ed, ee);
            checks++;
            if (v !== 1'b1 || e !== 1'b0 || d !== ed) begin
                errors++;
                $display("FAIL error_no_write_%0d: data=%h err=%b, want %h 0", i, d, e, ed);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ed [8]; logic ee;
        logic [31:0] sd;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h1122_3344;
        model_access(1'b1, 2'd2, 1'b0, 32'h0, 32'h1122_3344, sd, ee);
        @(negedge clk);
        req_write = 1'b0; req_wdata = 32'h0;
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_error !== 1'b0) begin
            errors++;
            $display("FAIL b2b_store_resp: valid=%b err=%b, want 1 0", resp_valid, resp_error);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h1122_3344) begin
            errors++;
            $display("FAIL b2b_load: valid=%b data=%h, want 1 11223344", resp_valid, resp_rdata);
        end
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i > 0) begin
                #1;
                checks++;
                if (resp_valid !== 1'b1 || resp_error !== 1'b0 || resp_rdata !== ed[i-1]) begin
                    errors++;
                    $display("FAIL b2b_burst_%0d: valid=%b err=%b data=%h, want 1 0 %h",
                             i - 1, resp_valid, resp_error, resp_rdata, ed[i-1]);
                end
            end
            if (i < 8) begin
                req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2;
                req_addr = 32'(i * 4);
                model_access(1'b0, 2'd2, 1'b0, 32'(i * 4), 32'h0, ed[i], ee);
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_burst_end: valid=%b, want 0", resp_valid);
        end
    endtask

    task automatic test_random();
        logic pend = 1'b0;
        logic pe, go;
        logic [31:0] pd;
        logic w, u; logic [1:0] sz; logic [31:0] a, wd;
        for (int c = 0; c < 301; c++) begin
            @(negedge clk); #1;
            checks++;
            if (pend) begin
                if (resp_valid !== 1'b1 || resp_error !== pe || resp_rdata !== pd) begin
                    errors++;
                    $display("FAIL random_%0d: valid=%b err=%b data=%h, want 1 %b %h",
                             c, resp_valid, resp_error, resp_rdata, pe, pd);
                end
            end else if (resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL random_idle_%0d: valid=%b, want 0", c, resp_valid);
            end
            go = (c < 300) && ($urandom_range(0, 3) != 0);
            if (go) begin
                w  = 1'($urandom_range(0, 1));
                u  = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 3));
                a  = 32'($urandom_range(0, MEM_BYTES + 7));
                wd = $urandom;
                req_write = w; req_unsigned = u; req_size = sz; req_addr = a; req_wdata = wd;
                model_access(w, sz, u, a, wd, pd, pe);
            end
            req_valid = go;
            pend = go;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_in_init();
        int unsigned n;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        count_ready_low(n);
        model_clear();
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL init_restart: ready low for %0d cycles, want 16", n);
        end
    endtask

    task automatic test_reset_inflight();
        int unsigned n;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0;
        @(negedge clk);
        req_valid = 1'b0; reset = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL inflight_drop: valid=%b, want 0", resp_valid);
        end
        @(negedge clk); reset = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL inflight_after_release: valid=%b, want 0", resp_valid);
        end
        count_ready_low(n);
        model_clear();
    endtask

    task automatic test_retention();
        logic rdy, v, e; logic [31:0] d, ed; logic ee;
        xfer(1'b1, 2'd2, 1'b0, 32'h14, 32'hCAFE_F00D, rdy, v, e, d);
        model_access(1'b1, 2'd2, 1'b0, 32'h14, 32'hCAFE_F00D, ed, ee);
        @(negedge clk); reset1 = 1'b1;
        @(negedge clk); reset1 = 1'b0;
        #1;
        checks++;
        if (ready1 !== 1'b1 || ready !== 1'b1) begin
            errors++;
            $display("FAIL retention_ready: ready1=%b ready=%b, want 1 1", ready1, ready);
        end
        xfer(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, rdy, v, e, d);
        model_access(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, ed, ee);
        checks++;
        if (obs1_v !== 1'b1 || obs1_d !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL retention_data: valid=%b data=%h, want 1 cafef00d", obs1_v, obs1_d);
        end
        checks++;
        if (v !== 1'b1 || d !== ed) begin
            errors++;
            $display("FAIL retention_clearing_dut: valid=%b data=%h, want 1 %h", v, d, ed);
        end
    endtask

    initial begin
        reset = 1'b1; reset1 = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        obs1_v = 1'b0; obs1_d = 32'h0;
        model_clear();
        repeat (3) @(negedge clk);
        test_reset();
        test_clear_sweep();
        test_extend();
        test_partial();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_in_init();
        test_reset_inflight();
        test_retention();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
